// File: rtl/pong_game_engine.sv
// Pong game-state engine: paddles, ball, velocity, scores and game FSM on a 640x480 field.
// Latency: state advances only on frame_tick cycles; outputs are registered, visible next cycle.
// Backpressure: none; the renderer samples the held outputs for the whole active frame.
module pong_game_engine #(
  parameter int BALL_SPEED   = 4,
  parameter int PADDLE_SPEED = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 5
) (
  input  logic       i_vgaclk,
  input  logic       i_reset,
  input  logic       i_frame_tick,
  input  logic       i_start,
  input  logic       i_p1_up,
  input  logic       i_p1_dn,
  input  logic       i_p2_up,
  input  logic       i_p2_dn,
  output logic [9:0] o_paddle1_y,
  output logic [9:0] o_paddle2_y,
  output logic [9:0] o_ball_x,
  output logic [9:0] o_ball_y,
  output logic [3:0] o_score1,
  output logic [3:0] o_score2,
  output logic       o_point_pulse,
  output logic       o_game_over
);

  // Field geometry shared with the renderer.
  localparam int FIELD_W   = 640;
  localparam int FIELD_H   = 480;
  localparam int PADDLE_W  = 10;
  localparam int PADDLE_H  = 60;
  localparam int BALL_SIZE = 8;
  localparam int PADDLE1_X = 30;
  localparam int PADDLE2_X = 600;

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  // Signed 11-bit copies so that ball/paddle arithmetic can dip below zero safely.
  localparam logic signed [10:0] L_BALL_STEP = 11'(BALL_SPEED);
  localparam logic signed [10:0] L_PAD_STEP  = 11'(PADDLE_SPEED);
  localparam logic signed [10:0] L_HALF_BALL = 11'(BALL_SIZE / 2);
  localparam logic signed [10:0] L_TOP_Y     = 11'(BALL_SIZE / 2);
  localparam logic signed [10:0] L_BOT_Y     = 11'(FIELD_H - 1 - BALL_SIZE / 2);
  localparam logic signed [10:0] L_PAD_MIN   = 11'(PADDLE_H / 2);
  localparam logic signed [10:0] L_PAD_MAX   = 11'(FIELD_H - PADDLE_H / 2);
  localparam logic signed [10:0] L_RFACE     = 11'(PADDLE2_X);
  localparam logic signed [10:0] L_LFACE     = 11'(PADDLE1_X + PADDLE_W);
  localparam logic signed [10:0] L_HIT       = 11'(PADDLE_H / 2 + BALL_SIZE / 2);
  localparam logic signed [10:0] L_XMAX      = 11'(FIELD_W);
  localparam logic signed [10:0] L_ZERO      = 11'sd0;

  localparam logic [9:0] L_TOP_Y10   = 10'(BALL_SIZE / 2);
  localparam logic [9:0] L_BOT_Y10   = 10'(FIELD_H - 1 - BALL_SIZE / 2);
  localparam logic [9:0] L_RBOUNCE_X = 10'(PADDLE2_X - BALL_SIZE / 2);
  localparam logic [9:0] L_LBOUNCE_X = 10'(PADDLE1_X + PADDLE_W + BALL_SIZE / 2);
  localparam logic [9:0] L_CX        = 10'(FIELD_W / 2);
  localparam logic [9:0] L_CY        = 10'(FIELD_H / 2);
  localparam logic [3:0] L_WIN       = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] L_SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_OVER
  } state_t;

  state_t           r_state;
  logic [9:0]       r_paddle1_y;
  logic [9:0]       r_paddle2_y;
  logic [9:0]       r_ball_x;
  logic [9:0]       r_ball_y;
  logic             r_dx_pos;
  logic             r_dy_pos;
  logic [3:0]       r_score1;
  logic [3:0]       r_score2;
  logic [CNT_W-1:0] r_serve_cnt;
  logic             r_point_pulse;
  logic             r_game_over;

  logic signed [10:0] w_bx;
  logic signed [10:0] w_by;
  logic signed [10:0] w_nx;
  logic signed [10:0] w_ny;
  logic signed [10:0] w_rel1;
  logic signed [10:0] w_rel2;
  logic               w_hit_r;
  logic               w_hit_l;
  logic               w_miss_r;
  logic               w_miss_l;
  logic [9:0]         w_next_bx;
  logic [9:0]         w_next_by;
  logic               w_next_dx_pos;
  logic               w_next_dy_pos;
  logic [3:0]         w_s1_inc;
  logic [3:0]         w_s2_inc;
  logic               w_game_end;
  logic [9:0]         w_p1_next;
  logic [9:0]         w_p2_next;

  // One paddle step: move on a single held button, clamp the centre to keep the paddle on screen.
  function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up, input logic dn);
    logic signed [10:0] t;
    t = $signed({1'b0, y});
    if (up && !dn) begin
      t = t - L_PAD_STEP;
      if (t < L_PAD_MIN) t = L_PAD_MIN;
    end else if (dn && !up) begin
      t = t + L_PAD_STEP;
      if (t > L_PAD_MAX) t = L_PAD_MAX;
    end
    return t[9:0];
  endfunction

  // Candidate ball step: walls, paddle faces (using pre-tick paddle positions) and misses.
  always_comb begin
    w_bx   = $signed({1'b0, r_ball_x});
    w_by   = $signed({1'b0, r_ball_y});
    w_nx   = r_dx_pos ? (w_bx + L_BALL_STEP) : (w_bx - L_BALL_STEP);
    w_ny   = r_dy_pos ? (w_by + L_BALL_STEP) : (w_by - L_BALL_STEP);
    w_rel1 = w_by - $signed({1'b0, r_paddle1_y});
    w_rel2 = w_by - $signed({1'b0, r_paddle2_y});

    w_next_by     = w_ny[9:0];
    w_next_dy_pos = r_dy_pos;
    if (!r_dy_pos && (w_ny <= L_TOP_Y)) begin
      w_next_by     = L_TOP_Y10;
      w_next_dy_pos = 1'b1;
    end else if (r_dy_pos && (w_ny >= L_BOT_Y)) begin
      w_next_by     = L_BOT_Y10;
      w_next_dy_pos = 1'b0;
    end

    // A hit needs the ball to start in front of the face and reach it within this step.
    w_hit_r = r_dx_pos && ((w_bx + L_HALF_BALL) <= L_RFACE) && ((w_nx + L_HALF_BALL) >= L_RFACE)
              && (w_rel2 < L_HIT) && (w_rel2 > -L_HIT);
    w_hit_l = !r_dx_pos && ((w_bx - L_HALF_BALL) >= L_LFACE) && ((w_nx - L_HALF_BALL) <= L_LFACE)
              && (w_rel1 < L_HIT) && (w_rel1 > -L_HIT);

    w_miss_r = !w_hit_r && !w_hit_l && ((w_nx + L_HALF_BALL) >= L_XMAX);
    w_miss_l = !w_hit_r && !w_hit_l && !w_miss_r && ((w_nx - L_HALF_BALL) <= L_ZERO);

    w_next_bx     = w_nx[9:0];
    w_next_dx_pos = r_dx_pos;
    if (w_hit_r) begin
      w_next_bx     = L_RBOUNCE_X;
      w_next_dx_pos = 1'b0;
    end else if (w_hit_l) begin
      w_next_bx     = L_LBOUNCE_X;
      w_next_dx_pos = 1'b1;
    end

    w_s1_inc   = (r_score1 >= L_WIN) ? r_score1 : (r_score1 + 4'd1);
    w_s2_inc   = (r_score2 >= L_WIN) ? r_score2 : (r_score2 + 4'd1);
    w_game_end = (w_miss_r && (w_s1_inc == L_WIN)) || (w_miss_l && (w_s2_inc == L_WIN));

    w_p1_next = paddle_step(r_paddle1_y, i_p1_up, i_p1_dn);
    w_p2_next = paddle_step(r_paddle2_y, i_p2_up, i_p2_dn);
  end

  // Game FSM and all game state, advanced once per frame tick.
  always_ff @(posedge i_vgaclk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_paddle1_y   <= L_CY;
      r_paddle2_y   <= L_CY;
      r_ball_x      <= L_CX;
      r_ball_y      <= L_CY;
      r_dx_pos      <= 1'b1;
      r_dy_pos      <= 1'b1;
      r_score1      <= 4'd0;
      r_score2      <= 4'd0;
      r_serve_cnt   <= '0;
      r_point_pulse <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_point_pulse <= 1'b0;
      if (i_frame_tick) begin
        case (r_state)
          ST_IDLE, ST_OVER: begin
            if (i_start) begin
              r_state     <= ST_SERVE;
              r_score1    <= 4'd0;
              r_score2    <= 4'd0;
              r_serve_cnt <= '0;
              r_ball_x    <= L_CX;
              r_ball_y    <= L_CY;
              r_game_over <= 1'b0;
            end
          end
          ST_SERVE: begin
            r_paddle1_y <= w_p1_next;
            r_paddle2_y <= w_p2_next;
            r_ball_x    <= L_CX;
            r_ball_y    <= L_CY;
            if (r_serve_cnt == L_SERVE_LAST) begin
              r_state     <= ST_PLAY;
              r_serve_cnt <= '0;
            end else begin
              r_serve_cnt <= r_serve_cnt + 1'b1;
            end
          end
          ST_PLAY: begin
            r_paddle1_y <= w_p1_next;
            r_paddle2_y <= w_p2_next;
            if (w_miss_r || w_miss_l) begin
              // Next serve heads toward whoever lost the point; dy carries over.
              r_point_pulse <= 1'b1;
              r_dx_pos      <= w_miss_r;
              if (w_miss_r) r_score1 <= w_s1_inc;
              else          r_score2 <= w_s2_inc;
              if (w_game_end) begin
                // Ball is left where it was when the final point was lost.
                r_state     <= ST_OVER;
                r_game_over <= 1'b1;
              end else begin
                r_state     <= ST_SERVE;
                r_serve_cnt <= '0;
                r_ball_x    <= L_CX;
                r_ball_y    <= L_CY;
              end
            end else begin
              r_ball_x <= w_next_bx;
              r_ball_y <= w_next_by;
              r_dx_pos <= w_next_dx_pos;
              r_dy_pos <= w_next_dy_pos;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_paddle1_y   = r_paddle1_y;
  assign o_paddle2_y   = r_paddle2_y;
  assign o_ball_x      = r_ball_x;
  assign o_ball_y      = r_ball_y;
  assign o_score1      = r_score1;
  assign o_score2      = r_score2;
  assign o_point_pulse = r_point_pulse;
  assign o_game_over   = r_game_over;

endmodule
